stopwatch_ctrl: RTL and testbench

Sequencing controller for the stopwatch digit chain. It turns three debounced push-button levels into a start/pause/lap/clear state machine and runs the millisecond prescaler. It drives the `time_ns` bus and the first-stage count enable that feed the `counter_flop` cascade. It also issues the digit-clear and display-freeze controls consumed by the VGA digit renderers.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/btn_edge.sv | 27 ++
 rtl/stopwatch_ctrl.sv | 131 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stopwatch_pkg : state encoding and default sizing for the stopwatch block  |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_TICK_CYCLES = 100000;
    localparam int          DEFAULT_CNT_W       = 20;

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_edge : rising-edge detector for one debounced button level             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    // Reset to 1 so a button held through reset release is not seen as a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stopwatch_ctrl : start/pause/lap/clear sequencer and millisecond prescaler |
// | Optional lap feature enabled by defining STOPWATCH_LAP_EN.                 |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES,
    parameter int          CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start_stop,
    input  logic             btn_lap,
    input  logic             btn_clear,
    output logic [CNT_W-1:0] time_ns,
    output logic             tick,
    output logic             clear,
    output logic             freeze,
    output logic             running,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] TICK_TOP = CNT_W'(TICK_CYCLES - 1);

    logic             ss_evt;
    logic             lap_evt;
    logic             clr_evt;
    state_t           cur_state;
    logic [CNT_W-1:0] count;
    logic             clear_q;
    logic             freeze_q;

    btn_edge u_edge_ss (
        .clk   (clk),
        .rst   (rst),
        .level (btn_start_stop),
        .rise  (ss_evt)
    );

    btn_edge u_edge_clr (
        .clk   (clk),
        .rst   (rst),
        .level (btn_clear),
        .rise  (clr_evt)
    );

`ifdef STOPWATCH_LAP_EN
    btn_edge u_edge_lap (
        .clk   (clk),
        .rst   (rst),
        .level (btn_lap),
        .rise  (lap_evt)
    );
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign lap_evt    = 1'b0;
`endif

    // The prescaler follows the current state, so the tick-cycle wrap still
    // happens on the edge that enters PAUSE and no tick is repeated on resume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= ST_IDLE;
            count     <= '0;
            clear_q   <= 1'b0;
            freeze_q  <= 1'b0;
        end else begin
            clear_q <= clr_evt;

            if (clr_evt) begin
                count <= '0;
            end else if (cur_state == ST_RUN || cur_state == ST_LAP) begin
                count <= (count == TICK_TOP) ? '0 : count + CNT_W'(1);
            end

            case (cur_state)
                ST_IDLE: begin
                    if (!clr_evt && ss_evt) begin
                        cur_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clr_evt) begin
                        cur_state <= ST_IDLE;
                    end else if (ss_evt) begin
                        cur_state <= ST_PAUSE;
                    end else if (lap_evt) begin
                        cur_state <= ST_LAP;
                        freeze_q  <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (clr_evt) begin
                        cur_state <= ST_IDLE;
                    end else if (ss_evt) begin
                        cur_state <= ST_RUN;
                    end
                end
                ST_LAP: begin
                    if (clr_evt) begin
                        cur_state <= ST_IDLE;
                        freeze_q  <= 1'b0;
                    end else if (ss_evt) begin
                        cur_state <= ST_PAUSE;
                        freeze_q  <= 1'b0;
                    end else if (lap_evt) begin
                        cur_state <= ST_RUN;
                        freeze_q  <= 1'b0;
                    end
                end
                default: begin
                    cur_state <= ST_IDLE;
                    freeze_q  <= 1'b0;
                end
            endcase
        end
    end

    assign running = (cur_state == ST_RUN) || (cur_state == ST_LAP);
    assign tick    = running && (count == TICK_TOP);
    assign time_ns = count;
    assign clear   = clear_q;
    assign freeze  = freeze_q;
    assign state   = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_stopwatch_ctrl : randomized, model-checked bench for stopwatch_ctrl     |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module tb_stopwatch_ctrl;

    localparam int T = 10;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        btn_start_stop;
    logic        btn_lap;
    logic        btn_clear;
    logic [19:0] time_ns;
    logic        tick;
    logic        clear;
    logic        freeze;
    logic        running;
    logic [1:0]  state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: mode (0 idle,1 run,2 pause,3 lap), running cycles since clear mod T.
    logic [1:0] m_st;
    int         m_cnt;
    bit         m_fr;
    bit         m_clr;
    bit         p_ss;
    bit         p_lp;
    bit         p_cl;

    stopwatch_ctrl #(
        .TICK_CYCLES (T),
        .CNT_W       (20)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .time_ns        (time_ns),
        .tick           (tick),
        .clear          (clear),
        .freeze         (freeze),
        .running        (running),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [25:0] dut_vec = {state, time_ns, tick, clear, freeze, running};

    function automatic logic [25:0] exp_vec();
        logic run;
        run = (m_st == 2'd1) || (m_st == 2'd3);
        return {m_st, 20'(m_cnt), run && (m_cnt == T - 1), m_clr, m_fr, run};
    endfunction

    task automatic model_step();
        bit e_ss, e_lp, e_cl, run;
        if (!rst) begin
            m_st = 2'd0; m_cnt = 0; m_fr = 1'b0; m_clr = 1'b0;
            p_ss = 1'b1; p_lp = 1'b1; p_cl = 1'b1;
            return;
        end
        e_ss = btn_start_stop & ~p_ss;
        e_lp = LAP_EN & btn_lap & ~p_lp;
        e_cl = btn_clear & ~p_cl;
        p_ss = btn_start_stop; p_lp = btn_lap; p_cl = btn_clear;
        run  = (m_st == 2'd1) || (m_st == 2'd3);
        m_clr = e_cl;
        if (e_cl)      m_cnt = 0;
        else if (run)  m_cnt = (m_cnt + 1) % T;
        if (e_cl) begin
            m_st = 2'd0; m_fr = 1'b0;
        end else if (e_ss) begin
            if (m_st == 2'd0 || m_st == 2'd2) m_st = 2'd1;
            else begin m_st = 2'd2; m_fr = 1'b0; end
        end else if (e_lp) begin
            if (m_st == 2'd1)      begin m_st = 2'd3; m_fr = 1'b1; end
            else if (m_st == 2'd3) begin m_st = 2'd1; m_fr = 1'b0; end
        end
    endtask

    task automatic drive(input bit ss, input bit lp, input bit cl);
        btn_start_stop = ss;
        btn_lap        = lp;
        btn_clear      = cl;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_cmp++;
            if (dut_vec !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_values: got %h expected %h", dut_vec, 26'd0);
            end
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_start();
        int run_idx = 0;
        int first   = -1;
        int last    = -1;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (running) run_idx++;
            n_cmp++;
            if (dut_vec !== exp_vec() || time_ns > 20'(T - 1)) begin
                n_fail++;
                $display("FAIL start_run: got %h expected %h", dut_vec, exp_vec());
            end
            if (tick) begin
                if (first < 0) begin
                    first = run_idx;
                end else begin
                    n_cmp++;
                    if (run_idx - last != T) begin
                        n_fail++;
                        $display("FAIL tick_period: got %0d expected %0d", run_idx - last, T);
                    end
                end
                last = run_idx;
            end
            drive(1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if (first != T) begin
            n_fail++;
            $display("FAIL first_tick: got run cycle %0d expected %0d", first, T);
        end
    endtask

    task automatic test_pause_mid();
        int held;
        int d;
        for (int i = 0; i < 2 * T && time_ns != 20'd4; i++) drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (time_ns !== 20'd4) begin
            n_fail++;
            $display("FAIL pause_mid_setup: got time_ns %0d expected 4", time_ns);
        end
        drive(1'b1, 1'b0, 1'b0);
        held = m_cnt;
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (state !== 2'd2 || tick !== 1'b0 || time_ns !== 20'(held) || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL pause_hold: got %h expected %h", dut_vec, exp_vec());
            end
            drive(1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0);
        d = 1;
        while (!tick && d < T + 2) begin
            drive(1'b0, 1'b0, 1'b0);
            d++;
        end
        n_cmp++;
        if (d != T - held) begin
            n_fail++;
            $display("FAIL resume_tick_delay: got %0d expected %0d", d, T - held);
        end
    endtask

    task automatic test_pause_on_tick();
        int ticks = 0;
        int d;
        for (int i = 0; i < T + 2 && !tick; i++) drive(1'b0, 1'b0, 1'b0);
        if (tick) ticks++;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (tick) ticks++;
            n_cmp++;
            if (state !== 2'd2 || time_ns !== 20'd0 || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL pause_on_tick: got %h expected %h", dut_vec, exp_vec());
            end
            drive(1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if (ticks != 1) begin
            n_fail++;
            $display("FAIL pause_tick_count: got %0d expected 1", ticks);
        end
        drive(1'b1, 1'b0, 1'b0);
        d = 1;
        while (!tick && d < T + 3) begin
            drive(1'b0, 1'b0, 1'b0);
            d++;
        end
        n_cmp++;
        if (d != T) begin
            n_fail++;
            $display("FAIL resume_after_tick_pause: got %0d expected %0d", d, T);
        end
    endtask

    task automatic test_lap();
        int k    = int'($urandom_range(2, 9));
        int last = -1;
        logic [1:0] lap_st;
        lap_st = LAP_EN ? 2'd3 : 2'd1;
        for (int i = 0; i < 45; i++) begin
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL lap_model: got %h expected %h", dut_vec, exp_vec());
            end
            if (i > k && i <= k + 20) begin
                n_cmp++;
                if (freeze !== LAP_EN || state !== lap_st) begin
                    n_fail++;
                    $display("FAIL lap_enter: got freeze %b state %0d expected freeze %b state %0d",
                             freeze, state, LAP_EN, lap_st);
                end
            end else if (i > k + 20) begin
                n_cmp++;
                if (freeze !== 1'b0 || state !== 2'd1) begin
                    n_fail++;
                    $display("FAIL lap_exit: got freeze %b state %0d expected freeze 0 state 1", freeze, state);
                end
            end
            if (tick) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (i - last != T) begin
                        n_fail++;
                        $display("FAIL lap_tick_period: got %0d expected %0d", i - last, T);
                    end
                end
                last = i;
            end
            drive(1'b0, (i == k) || (i == k + 20), 1'b0);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (state !== 2'd0 || clear !== 1'b1 || time_ns !== 20'd0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL clear_priority: got %h expected %h", dut_vec, exp_vec());
        end
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (clear !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL clear_one_cycle: got clear %b state %0d expected clear 0 state 0", clear, state);
        end
        drive(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (state !== 2'd0 || running !== 1'b0) begin
                n_fail++;
                $display("FAIL held_through_reset: got state %0d expected 0", state);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        bit ss = 1'b0, lp = 1'b0, cl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)  ss = ~ss;
            if ($urandom_range(0, 7) == 0)  lp = ~lp;
            if ($urandom_range(0, 29) == 0) cl = ~cl;
            rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            drive(ss, lp, cl);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        rst            = 1'b0;
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        m_st = 2'd0; m_cnt = 0; m_fr = 1'b0; m_clr = 1'b0;
        p_ss = 1'b1; p_lp = 1'b1; p_cl = 1'b1;
        @(negedge clk);
        test_reset();
        test_start();
        test_pause_mid();
        test_pause_on_tick();
        test_lap();
        test_simultaneous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
